// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by a DEPTH-word register memory, one INCR burst in flight at a time.
// Optional feature macro: AXI_SLAVE_RANGE_CHECK_EN (flag beats beyond the memory instead of wrapping).
module axi_slave_mem #(
    parameter int DEPTH = 8
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    localparam int IDX_W = $clog2(DEPTH);
`ifdef AXI_SLAVE_RANGE_CHECK_EN
    // One spare bit so a burst starting near the top of the address space cannot wrap back in range.
    localparam int AW = 31;
`else
    localparam int AW = IDX_W;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [AW-1:0] waddr_t;
    typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_t;

    state_t      state;
    waddr_t      addr_q;
    logic [7:0]  count_q;
    logic [7:0]  len_q;
    logic        err_q;
    logic [31:0] mem [DEPTH];

    waddr_t ar_start, aw_start, next_addr;
    logic   cur_ok, ar_ok, next_ok;
    logic   unused_addr_bits;

`ifdef AXI_SLAVE_RANGE_CHECK_EN
    assign ar_start = {1'b0, araddr[31:2]};
    assign aw_start = {1'b0, awaddr[31:2]};
    assign cur_ok   = addr_q < waddr_t'(DEPTH);
    assign ar_ok    = ar_start < waddr_t'(DEPTH);
    assign next_ok  = next_addr < waddr_t'(DEPTH);
    assign unused_addr_bits = ^{araddr[1:0], awaddr[1:0]};
`else
    assign ar_start = araddr[IDX_W+1:2];
    assign aw_start = awaddr[IDX_W+1:2];
    assign cur_ok   = 1'b1;
    assign ar_ok    = 1'b1;
    assign next_ok  = 1'b1;
    assign unused_addr_bits = ^{araddr[31:IDX_W+2], araddr[1:0],
                                awaddr[31:IDX_W+2], awaddr[1:0]};
`endif

    assign next_addr = addr_q + waddr_t'(1);

    logic [IDX_W-1:0] cur_idx, ar_idx, next_idx;
    assign cur_idx  = addr_q[IDX_W-1:0];
    assign ar_idx   = ar_start[IDX_W-1:0];
    assign next_idx = next_addr[IDX_W-1:0];

    // Address ready decodes from state so a released reset shows arready on the very next cycle.
    assign arready = (state == IDLE) && !areset;
    assign awready = (state == IDLE) && !arvalid && !areset;

    logic ar_fire, aw_fire, r_fire, w_fire, w_err;
    assign ar_fire = arvalid && arready;
    assign aw_fire = awvalid && awready;
    assign r_fire  = rvalid && rready;
    assign w_fire  = wvalid && wready;

    // Sticky error including this beat: out of range, early wlast, or a missing wlast on the final beat.
    assign w_err = err_q || !cur_ok || (wlast ? (count_q != len_q) : (count_q == len_q));

    // NOTE: the memory is cleared by reset, so it is built from flops and will not map onto a RAM macro.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (w_fire && cur_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[cur_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_fire) begin
                        state   <= RDATA;
                        addr_q  <= ar_start;
                        count_q <= '0;
                        len_q   <= arlen;
                        rvalid  <= 1'b1;
                        rdata   <= ar_ok ? mem[ar_idx] : '0;
                        rresp   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                        rlast   <= (arlen == 8'd0);
                    end else if (aw_fire) begin
                        state   <= WDATA;
                        addr_q  <= aw_start;
                        count_q <= '0;
                        len_q   <= awlen;
                        err_q   <= 1'b0;
                        wready  <= 1'b1;
                    end
                end
                RDATA: begin
                    if (r_fire) begin
                        if (rlast) begin
                            state  <= IDLE;
                            rvalid <= 1'b0;
                            rdata  <= '0;
                            rresp  <= RESP_OKAY;
                            rlast  <= 1'b0;
                        end else begin
                            addr_q  <= next_addr;
                            count_q <= count_q + 8'd1;
                            rdata   <= next_ok ? mem[next_idx] : '0;
                            rresp   <= next_ok ? RESP_OKAY : RESP_SLVERR;
                            rlast   <= (count_q + 8'd1 == len_q);
                        end
                    end
                end
                WDATA: begin
                    if (w_fire) begin
                        addr_q  <= next_addr;
                        count_q <= count_q + 8'd1;
                        err_q   <= w_err;
                        if (wlast) begin
                            state  <= WRESP;
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bresp  <= w_err ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                WRESP: begin
                    if (bready) begin
                        state  <= IDLE;
                        bvalid <= 1'b0;
                        bresp  <= RESP_OKAY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: drivers push expected beats/responses from a word-array model,
// a negedge monitor pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_axi_slave_mem;

    localparam int DEPTH = 8;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    axi_slave_mem #(.DEPTH(DEPTH)) dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      rd_q[$];
    logic [1:0]  b_q[$];
    logic [31:0] mem_m [DEPTH];
    int          checks = 0;
    int          errors = 0;
    bit          rr_auto = 1'b1;
    bit          br_auto = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic abort(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "bench aborted");
    endtask

    // Reference model: plain word numbers, no wrap unless the memory is configured to wrap.
    function automatic bit word_ok(input longint w);
`ifdef AXI_SLAVE_RANGE_CHECK_EN
        return w < DEPTH;
`else
        return w >= 0;
`endif
    endfunction

    task automatic expect_read(input logic [31:0] addr, input int len);
        for (int i = 0; i <= len; i++) begin
            longint w = longint'(addr >> 2) + i;
            rbeat_t e;
            e.data = word_ok(w) ? mem_m[int'(w % DEPTH)] : 32'h0;
            e.resp = word_ok(w) ? 2'b00 : 2'b10;
            e.last = (i == len);
            rd_q.push_back(e);
        end
    endtask

    task automatic model_write(input logic [31:0] addr, input int len, input int nbeats,
                               input logic [31:0] d[$], input logic [3:0] s[$]);
        bit err = (nbeats != len + 1);
        for (int i = 0; i < nbeats; i++) begin
            longint w = longint'(addr >> 2) + i;
            if (word_ok(w)) begin
                for (int b = 0; b < 4; b++)
                    if (s[i][b]) mem_m[int'(w % DEPTH)][8*b +: 8] = d[i][8*b +: 8];
            end else begin
                err = 1'b1;
            end
        end
        b_q.push_back(err ? 2'b10 : 2'b00);
    endtask

    function automatic logic ready_of(input int ch);
        case (ch)
            0:       return awready;
            1:       return wready;
            default: return arready;
        endcase
    endfunction

    // Enter at posedge+1 with valid raised; leave at posedge+1 just after the handshake edge.
    task automatic wait_ready(input int ch, input string name);
        int n = 0;
        forever begin
            @(negedge aclk);
            if (ready_of(ch)) break;
            n++;
            if (n > 500) abort(name);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (rd_q.size() != 0 || b_q.size() != 0) begin
            @(posedge aclk);
            n++;
            if (n > 1000) abort("drain");
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic read_addr_phase(input logic [31:0] addr, input int len);
        araddr  = addr;
        arlen   = 8'(len);
        arvalid = 1'b1;
        wait_ready(2, "ar_timeout");
        arvalid = 1'b0;
        @(negedge aclk);
        check("rvalid_after_ar", 32'(rvalid), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int len);
        expect_read(addr, len);
        read_addr_phase(addr, len);
        wait_drain();
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input int nbeats,
                            input logic [31:0] base, input bit rnd);
        logic [31:0] d[$];
        logic [3:0]  s[$];
        for (int i = 0; i < nbeats; i++) begin
            d.push_back(rnd ? 32'($urandom) : base + 32'(i));
            s.push_back(rnd ? 4'($urandom_range(0, 15)) : 4'hF);
        end
        model_write(addr, len, nbeats, d, s);
        awaddr  = addr;
        awlen   = 8'(len);
        awvalid = 1'b1;
        wait_ready(0, "aw_timeout");
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
            wdata  = d[i];
            wstrb  = s[i];
            wlast  = (i == nbeats - 1);
            wvalid = 1'b1;
            wait_ready(1, "w_timeout");
            wvalid = 1'b0;
            wlast  = 1'b0;
        end
        @(negedge aclk);
        check("bvalid_after_wlast", 32'(bvalid), 32'd1);
    endtask

    task automatic txn_write(input logic [31:0] addr, input int len, input int nbeats,
                             input logic [31:0] base, input bit rnd);
        do_write(addr, len, nbeats, base, rnd);
        wait_drain();
    endtask

    task automatic set_rready_manual(input bit manual, input logic level);
        @(negedge aclk);
        rr_auto = !manual;
        rready  = level;
        @(posedge aclk);
        #1;
    endtask

    // Random ready generators for the response channels.
    initial forever begin
        @(posedge aclk);
        #1;
        if (rr_auto) rready = ($urandom_range(0, 3) != 0);
        if (br_auto) bready = ($urandom_range(0, 2) != 0);
    end

    // Monitor: compares every presented beat/response against the scoreboard queues.
    initial forever begin
        @(negedge aclk);
        if (!areset) begin
            if (rvalid) begin
                if (rd_q.size() == 0) begin
                    check("r_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rdata", rdata, rd_q[0].data);
                    check("rresp", 32'(rresp), 32'(rd_q[0].resp));
                    check("rlast", 32'(rlast), 32'(rd_q[0].last));
                    if (rready) void'(rd_q.pop_front());
                end
            end else begin
                check("r_idle_zero", rdata | 32'({rresp, rlast}), 32'd0);
            end
            if (bvalid) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected", 32'd1, 32'd0);
                end else begin
                    check("bresp", 32'(bresp), 32'(b_q[0]));
                    if (bready) void'(b_q.pop_front());
                end
            end else begin
                check("b_idle_zero", 32'(bresp), 32'd0);
            end
            if (rvalid || wready || bvalid)
                check("addr_ready_busy", 32'({arready, awready}), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        abort("watchdog");
    end

    initial begin
        areset  = 1'b1;
        awaddr  = '0; awlen = '0; awvalid = 1'b0;
        wdata   = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        araddr  = '0; arlen = '0; arvalid = 1'b0;
        rready  = 1'b0; bready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        repeat (2) @(negedge aclk);
        check("reset_outputs", 32'({arready, awready, rvalid, wready, bvalid}), 32'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("post_reset_arready", 32'(arready), 32'd1);
        check("post_reset_awready", 32'(awready), 32'd1);
        @(posedge aclk);
        #1;

        // Basic burst write then read-back.
        txn_write(32'h4, 3, 4, 32'hDEADBEEF, 1'b0);
        do_read(32'h4, 3);

        // Burst crossing the top of the memory.
        txn_write(32'h1C, 1, 2, 32'hA5A50000, 1'b0);
        do_read(32'h18, 3);

        // Read stalled on beat 2 for three cycles, then an early-wlast write.
        set_rready_manual(1'b1, 1'b1);
        expect_read(32'h4, 3);
        read_addr_phase(32'h4, 3);
        @(posedge aclk);
        #1;
        rready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        rready = 1'b1;
        wait_drain();
        set_rready_manual(1'b0, 1'b1);
        txn_write(32'h8, 3, 2, 32'h12340000, 1'b0);
        txn_write(32'h0, 1, 3, 32'h55AA0000, 1'b0);

        // Simultaneous requests: read accepted first, write waits for IDLE.
        expect_read(32'h0, 2);
        fork
            begin
                read_addr_phase(32'h0, 2);
                check("aw_blocked_by_read", 32'(awready), 32'd0);
            end
            do_write(32'h10, 2, 3, 32'hCAFE0000, 1'b0);
        join
        wait_drain();
        do_read(32'h10, 2);

        // Randomized mix of reads and writes, including malformed wlast placement.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a = 32'($urandom_range(0, DEPTH * 8 - 1));
            int len = $urandom_range(0, 19);
            if ($urandom_range(0, 1) == 1) begin
                do_read(a, len);
            end else begin
                int nb = len + 1;
                int k = $urandom_range(0, 5);
                if (k == 0 && nb > 1) nb = nb - 1;
                if (k == 1) nb = nb + 1;
                txn_write(a, len, nb, 32'h0, 1'b1);
            end
        end

        // Reset in the middle of a read burst.
        set_rready_manual(1'b1, 1'b0);
        expect_read(32'h0, 3);
        read_addr_phase(32'h0, 3);
        @(posedge aclk);
        #2;
        areset = 1'b1;
        #1;
        check("reset_mid_read", 32'({rvalid, arready, awready, rlast}), 32'd0);
        rd_q.delete();
        b_q.delete();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        @(posedge aclk);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        #1;
        check("arready_after_reset", 32'(arready), 32'd1);
        set_rready_manual(1'b0, 1'b1);
        do_read(32'h4, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
